// File: rtl/ram_sweep_ctrl.sv
// rtl/ram_sweep_ctrl.sv - single-port RAM with manual access plus hardware fill and scan sweeps
module ram_sweep_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              fill_req,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              scan_req,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] raddr,
  output logic              rvalid,
  output logic              rlast,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_SCAN = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] fill_q, fill_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_next;
  logic              done_d;
  logic              last_d;
  logic              sweep_end;

  logic [DATA_W-1:0] mem [DEPTH];

  assign sweep_end = (cnt_q == LAST_ADDR);
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = wdata;
    rd_en     = 1'b0;
    rd_addr   = addr;
    done_d    = 1'b0;
    last_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fill_req) begin
          fill_d  = fill_value;
          cnt_d   = '0;
          state_d = S_FILL;
        end else if (scan_req) begin
          cnt_d   = '0;
          state_d = S_SCAN;
        end else begin
          mem_we = wr_req;
          rd_en  = rd_req;
        end
      end
      S_FILL: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = fill_q;
        if (sweep_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      S_SCAN: begin
        rd_en   = 1'b1;
        rd_addr = cnt_q;
        last_d  = sweep_end;
        if (sweep_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A same-cycle write to the address being read forwards the new data.
  always_comb begin
    rd_next = mem[rd_addr];
    if (mem_we && (mem_waddr == rd_addr)) rd_next = mem_wdata;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
      rdata   <= '0;
      raddr   <= '0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      rvalid  <= rd_en;
      rlast   <= last_d;
      done    <= done_d;
      if (rd_en) begin
        rdata <= rd_next;
        raddr <= rd_addr;
      end
    end
  end

  // Array has no reset; writes are blocked while resetn is low so an abort stops the fill at once.
  always_ff @(posedge clock) begin
    if (mem_we && resetn) mem[mem_waddr] <= mem_wdata;
  end

endmodule
